// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states
// and the bit layout of the packed flag vector returned to requesters.
package alu_arbiter_pkg;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_ADD  = 4'b0001;
  localparam logic [3:0] ALUC_SUBU = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic zero, input logic carry,
                                            input logic neg, input logic ovf);
    logic [3:0] f;
    f             = 4'b0000;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = carry;
    f[FLAG_NEG]   = neg;
    f[FLAG_OVF]   = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin winner selection: a lone requester always wins, a tie
// goes to whichever requester was not granted last.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    case (valid_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters:
// operands are registered onto the ALU, the result is captured and held per requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_aluc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_aluc,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic             grant_id_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_aluc_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_r_q [2];
  logic [3:0]       rsp_flags_q [2];

  logic [1:0]       req_valid_w;
  logic [1:0]       req_ready_w;
  logic [1:0]       rsp_ready_w;
  logic [WIDTH-1:0] req_a_w [2];
  logic [WIDTH-1:0] req_b_w [2];
  logic [3:0]       req_aluc_w [2];
  logic             winner_w;
  logic             req_fire_w;
  logic [3:0]       alu_flags_w;

  assign req_valid_w   = {req1_valid, req0_valid};
  assign rsp_ready_w   = {rsp1_ready, rsp0_ready};
  assign req_a_w[0]    = req0_a;
  assign req_a_w[1]    = req1_a;
  assign req_b_w[0]    = req0_b;
  assign req_b_w[1]    = req1_b;
  assign req_aluc_w[0] = req0_aluc;
  assign req_aluc_w[1] = req1_aluc;

  rr_arbiter2 u_rr (
    .valid_i      (req_valid_w),
    .last_grant_i (last_grant_q),
    .winner_o     (winner_w)
  );

  // Ready depends only on registered state and the live valids, never on operands.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready_w[gi] = (state_q == ST_IDLE) && (winner_w == 1'(gi)) && req_valid_w[gi];
    end
  endgenerate

  assign req_fire_w  = |req_ready_w;
  assign alu_flags_w = pack_flags(alu_zero, alu_carry, alu_negative, alu_overflow);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      grant_id_q     <= 1'b0;
      cnt_q          <= 4'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_aluc_q     <= 4'd0;
      rsp_valid_q    <= 2'b00;
      rsp_r_q[0]     <= '0;
      rsp_r_q[1]     <= '0;
      rsp_flags_q[0] <= 4'd0;
      rsp_flags_q[1] <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire_w) begin
            alu_a_q      <= req_a_w[winner_w];
            alu_b_q      <= req_b_w[winner_w];
            alu_aluc_q   <= req_aluc_w[winner_w];
            grant_id_q   <= winner_w;
            last_grant_q <= winner_w;
            cnt_q        <= CNT_INIT;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_r_q[grant_id_q]     <= alu_r;
            rsp_flags_q[grant_id_q] <= alu_flags_w;
            rsp_valid_q[grant_id_q] <= 1'b1;
            state_q                 <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_w[grant_id_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = req_ready_w[0];
  assign req1_ready = req_ready_w[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_r     = rsp_r_q[0];
  assign rsp1_r     = rsp_r_q[1];
  assign rsp0_flags = rsp_flags_q[0];
  assign rsp1_flags = rsp_flags_q[1];
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_aluc   = alu_aluc_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 runs with EXEC_CYCLES=1, instance 1 with 3,
// each driving its own behavioural ALU; a transaction-level model predicts outputs.
module tb_alu_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid [NI];
  logic [31:0] req_a     [NI][2];
  logic [31:0] req_b     [NI][2];
  logic [3:0]  req_aluc  [NI][2];
  logic [1:0]  rsp_ready [NI];

  wire [1:0]  req_ready [NI];
  wire [1:0]  rsp_valid [NI];
  wire [31:0] rsp_r     [NI][2];
  wire [3:0]  rsp_flags [NI][2];
  wire [31:0] alu_a     [NI];
  wire [31:0] alu_b     [NI];
  wire [3:0]  alu_aluc  [NI];
  wire        busy      [NI];
  wire        grant     [NI];

  // Reference ALU: returns {overflow, negative, carry, zero, r}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = 33'd0; r = a; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'b0001: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0010: begin r = a - b; c = (a < b); end
      4'b0011: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1010: r = {31'd0, (a < b)};
      4'b1011: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = a;
    endcase
    return {v, r[31], c, (r == 32'd0), r};
  endfunction

  function automatic int exec_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      logic        rdy0, rdy1, rv0, rv1, o_busy, o_gnt;
      logic [31:0] o_r0, o_r1, o_aa, o_ab;
      logic [3:0]  o_f0, o_f1, o_ac;
      logic [35:0] alu_out;

      always_comb alu_out = alu_fn(o_aa, o_ab, o_ac);

      alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(gi == 0 ? 1 : 3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req_valid[gi][0]),
        .req0_ready   (rdy0),
        .req0_a       (req_a[gi][0]),
        .req0_b       (req_b[gi][0]),
        .req0_aluc    (req_aluc[gi][0]),
        .req1_valid   (req_valid[gi][1]),
        .req1_ready   (rdy1),
        .req1_a       (req_a[gi][1]),
        .req1_b       (req_b[gi][1]),
        .req1_aluc    (req_aluc[gi][1]),
        .rsp0_valid   (rv0),
        .rsp0_ready   (rsp_ready[gi][0]),
        .rsp0_r       (o_r0),
        .rsp0_flags   (o_f0),
        .rsp1_valid   (rv1),
        .rsp1_ready   (rsp_ready[gi][1]),
        .rsp1_r       (o_r1),
        .rsp1_flags   (o_f1),
        .alu_a        (o_aa),
        .alu_b        (o_ab),
        .alu_aluc     (o_ac),
        .alu_r        (alu_out[31:0]),
        .alu_zero     (alu_out[32]),
        .alu_carry    (alu_out[33]),
        .alu_negative (alu_out[34]),
        .alu_overflow (alu_out[35]),
        .busy         (o_busy),
        .grant_id     (o_gnt)
      );

      assign req_ready[gi]    = {rdy1, rdy0};
      assign rsp_valid[gi]    = {rv1, rv0};
      assign rsp_r[gi][0]     = o_r0;
      assign rsp_r[gi][1]     = o_r1;
      assign rsp_flags[gi][0] = o_f0;
      assign rsp_flags[gi][1] = o_f1;
      assign alu_a[gi]        = o_aa;
      assign alu_b[gi]        = o_ab;
      assign alu_aluc[gi]     = o_ac;
      assign busy[gi]         = o_busy;
      assign grant[gi]        = o_gnt;
    end
  endgenerate

  // Transaction-level model state per instance.
  bit          pend    [NI];
  bit          own     [NI];
  bit          last_g  [NI];
  bit          gnt     [NI];
  int          rsp_at  [NI];
  logic [35:0] exp_res [NI];
  logic [31:0] ea      [NI];
  logic [31:0] eb      [NI];
  logic [3:0]  ec      [NI];
  logic [31:0] held_r  [NI][2];
  logic [3:0]  held_f  [NI][2];
  logic [1:0]  acc     [NI];
  int          acc_log [$];
  int          acc_cyc [$];
  int          cyc;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string tg(input int k, input string s);
    return $sformatf("i%0d.%s", k, s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      pend[k] = 0; own[k] = 0; last_g[k] = 1; gnt[k] = 0; rsp_at[k] = 0;
      exp_res[k] = '0; ea[k] = '0; eb[k] = '0; ec[k] = '0; acc[k] = 2'b00;
      for (int n = 0; n < 2; n++) begin
        held_r[k][n] = '0;
        held_f[k][n] = '0;
      end
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 2'b00;
      rsp_ready[k] = 2'b00;
      for (int n = 0; n < 2; n++) begin
        req_a[k][n] = '0; req_b[k][n] = '0; req_aluc[k][n] = '0;
      end
    end
  endtask

  // Compare the current cycle against the model, then advance the model past the edge.
  task automatic step();
    logic [1:0] v, exp_rdy, exp_rv;
    logic       w;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      v = req_valid[k];
      w = (v == 2'b11) ? ~last_g[k] : v[1];
      exp_rdy = 2'b00;
      if (!pend[k] && v != 2'b00) exp_rdy[w] = 1'b1;
      exp_rv = 2'b00;
      if (pend[k] && cyc >= rsp_at[k]) begin
        exp_rv[own[k]]    = 1'b1;
        held_r[k][own[k]] = exp_res[k][31:0];
        held_f[k][own[k]] = exp_res[k][35:32];
      end
      check_val(tg(k, "req_ready"), 64'(req_ready[k]), 64'(exp_rdy));
      check_val(tg(k, "rsp_valid"), 64'(rsp_valid[k]), 64'(exp_rv));
      check_val(tg(k, "busy"), 64'(busy[k]), 64'(pend[k]));
      check_val(tg(k, "grant_id"), 64'(grant[k]), 64'(gnt[k]));
      check_val(tg(k, "alu_a"), 64'(alu_a[k]), 64'(ea[k]));
      check_val(tg(k, "alu_b"), 64'(alu_b[k]), 64'(eb[k]));
      check_val(tg(k, "alu_aluc"), 64'(alu_aluc[k]), 64'(ec[k]));
      for (int n = 0; n < 2; n++) begin
        check_val(tg(k, $sformatf("rsp%0d_r", n)), 64'(rsp_r[k][n]), 64'(held_r[k][n]));
        check_val(tg(k, $sformatf("rsp%0d_flags", n)), 64'(rsp_flags[k][n]), 64'(held_f[k][n]));
        if (req_ready[k][n] && v[n]) begin
          acc_log.push_back(n);
          acc_cyc.push_back(cyc);
        end
      end
      acc[k] = 2'b00;
      if (!rst) begin
        if (!pend[k] && v != 2'b00) begin
          pend[k] = 1; own[k] = w; last_g[k] = w; gnt[k] = w;
          ea[k] = req_a[k][w]; eb[k] = req_b[k][w]; ec[k] = req_aluc[k][w];
          exp_res[k] = alu_fn(ea[k], eb[k], ec[k]);
          rsp_at[k]  = cyc + exec_of(k) + 1;
          acc[k][w]  = 1'b1;
        end else if (pend[k] && cyc >= rsp_at[k] && rsp_ready[k][own[k]]) begin
          pend[k] = 0;
          $display("txn i%0d req%0d a=%08h b=%08h aluc=%h r=%08h flags=%b cyc=%0d",
                   k, own[k], ea[k], eb[k], ec[k], exp_res[k][31:0], exp_res[k][35:32], cyc);
        end
      end
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_op(input int k, input int n);
    req_valid[k][n] = 1'b1;
    req_a[k][n]     = $urandom;
    req_b[k][n]     = ($urandom_range(0, 3) == 0) ? req_a[k][n] : $urandom;
    req_aluc[k][n]  = 4'($urandom_range(0, 15));
  endtask

  task automatic set_op(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    req_valid[k][n] = 1'b1;
    req_a[k][n] = a; req_b[k][n] = b; req_aluc[k][n] = op;
  endtask

  task automatic wait_rsp(input int k, input int n, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid[k][n]) begin
        seen = 1;
        break;
      end
      step();
    end
    check_val(tg(k, tag), 64'(seen), 64'd1);
  endtask

  task automatic drain(input int k);
    req_valid[k] = 2'b00;
    rsp_ready[k] = 2'b11;
    for (int i = 0; i < 40 && pend[k]; i++) step();
    check_val(tg(k, "drain"), 64'(pend[k]), 64'd0);
    step();
    rsp_ready[k] = 2'b00;
  endtask

  task automatic run_random(input int k, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (req_valid[k][n] && !acc[k][n]) begin
          if ($urandom_range(0, 15) == 0) req_valid[k][n] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rand_op(k, n);
        end else begin
          req_valid[k][n] = 1'b0;
        end
      end
      rsp_ready[k] = 2'($urandom_range(0, 3));
      step();
    end
    drain(k);
  endtask

  initial begin
    int          c0;
    int          ones;
    logic [35:0] e;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single op on the EXEC_CYCLES=1 instance.
    set_op(0, 0, 32'h0000_0005, 32'hffff_000f, 4'b0000);
    c0 = cyc;
    step();
    req_valid[0] = 2'b00;
    wait_rsp(0, 0, "single_wait");
    check_val("single_latency", 64'(cyc - c0), 64'd2);
    check_val("single_r", 64'(rsp_r[0][0]), 64'h0000_0000_ffff_0014);
    check_val("single_flags", 64'(rsp_flags[0][0]), 64'b0100);
    check_val("single_rsp1_valid", 64'(rsp_valid[0][1]), 64'd0);
    drain(0);

    // Tie straight out of reset: requester 0 first, requester 1 right after.
    do_reset();
    acc_log.delete();
    acc_cyc.delete();
    set_op(0, 0, 32'd1, 32'd2, 4'b0000);
    set_op(0, 1, 32'd5, 32'd5, 4'b0010);
    rsp_ready[0] = 2'b11;
    step();
    req_valid[0][0] = 1'b0;
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
    req_valid[0][1] = 1'b0;
    check_val("tie_count", 64'(acc_log.size()), 64'd2);
    check_val("tie_first", 64'(acc_log[0]), 64'd0);
    check_val("tie_second", 64'(acc_log[1]), 64'd1);
    check_val("tie_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    wait_rsp(0, 1, "tie_wait");
    check_val("tie_r", 64'(rsp_r[0][1]), 64'd0);
    check_val("tie_zero", 64'(rsp_flags[0][1][0]), 64'd1);
    drain(0);

    // Fairness: both requesters continuously valid.
    do_reset();
    acc_log.delete();
    acc_cyc.delete();
    rand_op(0, 0);
    rand_op(0, 1);
    rsp_ready[0] = 2'b11;
    for (int i = 0; i < 60 && acc_log.size() < 6; i++) begin
      step();
      for (int n = 0; n < 2; n++) if (acc[0][n]) rand_op(0, n);
    end
    check_val("fair_count", 64'(acc_log.size()), 64'd6);
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("fair_grant%0d", i), 64'(acc_log[i]), 64'(i % 2));
      ones += acc_log[i];
    end
    check_val("fair_no_starve", 64'(ones), 64'd3);
    drain(0);

    // Backpressure: response held while requester 1 waits.
    do_reset();
    set_op(0, 0, 32'h8000_0001, 32'h8000_0002, 4'b0001);
    e = alu_fn(32'h8000_0001, 32'h8000_0002, 4'b0001);
    step();
    req_valid[0][0] = 1'b0;
    rand_op(0, 1);
    wait_rsp(0, 0, "bp_wait");
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid", 64'(rsp_valid[0]), 64'b01);
      check_val("bp_r", 64'(rsp_r[0][0]), 64'(e[31:0]));
      check_val("bp_flags", 64'(rsp_flags[0][0]), 64'(e[35:32]));
      check_val("bp_req_ready", 64'(req_ready[0]), 64'd0);
      check_val("bp_busy", 64'(busy[0]), 64'd1);
      step();
    end
    drain(0);

    // Latency with EXEC_CYCLES=3.
    do_reset();
    set_op(1, 0, 32'h1234_5678, 32'h0000_1111, 4'b0010);
    step();
    req_valid[1] = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      check_val("lat_alu_a", 64'(alu_a[1]), 64'h1234_5678);
      check_val("lat_alu_b", 64'(alu_b[1]), 64'h0000_1111);
      check_val("lat_alu_aluc", 64'(alu_aluc[1]), 64'b0010);
      check_val("lat_rsp_early", 64'(rsp_valid[1]), 64'd0);
      step();
    end
    check_val("lat_rsp_rise", 64'(rsp_valid[1]), 64'b01);
    check_val("lat_r", 64'(rsp_r[1][0]), 64'h1234_4567);
    drain(1);

    // Reset in the middle of EXEC, then the request is re-presented.
    set_op(1, 0, 32'h7fff_ffff, 32'h0000_0001, 4'b0001);
    step();
    req_valid[1] = 2'b00;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    check_val("mid_rst_busy", 64'(busy[1]), 64'd0);
    check_val("mid_rst_alu_a", 64'(alu_a[1]), 64'd0);
    check_val("mid_rst_alu_aluc", 64'(alu_aluc[1]), 64'd0);
    set_op(1, 0, 32'h7fff_ffff, 32'h0000_0001, 4'b0001);
    step();
    req_valid[1] = 2'b00;
    wait_rsp(1, 0, "mid_rst_wait");
    check_val("mid_rst_r", 64'(rsp_r[1][0]), 64'h8000_0000);
    check_val("mid_rst_flags", 64'(rsp_flags[1][0]), 64'b1100);
    drain(1);

    run_random(0, 800);
    run_random(1, 800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (aluc-coded; r, zero, carry, negative, overflow outputs) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are registered before they drive the ALU, and results plus flags are captured and held until the winner accepts them.
- The block sits between the ALU instance and the two client units, for example the execute stage and a multi-cycle helper.

Parameters:
WIDTH, 32, operand/result width
EXEC_CYCLES, 1, cycles operands are held on the ALU before capture (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req0_aluc  in  4  ALU op code
req1_valid/req1_ready/req1_a/req1_b/req1_aluc  same as requester 0
rsp0_valid  out  1  result for requester 0 valid
rsp0_ready  in  1  requester 0 takes result
rsp0_r  out  WIDTH  result
rsp0_flags  out  4  {overflow, negative, carry, zero}
rsp1_valid/rsp1_ready/rsp1_r/rsp1_flags  same as requester 0
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
alu_aluc  out  4  ALU op code
alu_r  in  WIDTH  ALU result
alu_zero/alu_carry/alu_negative/alu_overflow  in  1 each  ALU flags
busy  out  1  high when state is not IDLE
grant_id  out  1  requester currently owning the ALU

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - rsp*_valid=0, rsp*_r=0, rsp*_flags=0.
  - alu_a=0, alu_b=0, alu_aluc=0.
  - busy=0, grant_id=0, exec counter=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner selection: if only one req*_valid is high, that requester wins. If both are high, the requester != last_grant wins.
  - reqN_ready = (state==IDLE) && winner==N && reqN_valid. This is combinational from registered state and valid; it is 0 outside IDLE.
  - On handshake in cycle C:
    - latch a, b and aluc into the alu_* registers;
    - set grant_id and last_grant to the winner;
    - load exec counter with EXEC_CYCLES-1;
    - move to EXEC.
- EXEC (cycles C+1..C+EXEC_CYCLES):
  - alu_* hold stable; the counter decrements each cycle.
  - When counter==0, at that edge capture alu_r and {alu_overflow, alu_negative, alu_carry, alu_zero} into the response registers of grant_id, then move to RESP.
- RESP:
  - rsp[grant_id]_valid rises in cycle C+EXEC_CYCLES+1 and holds, with r and flags stable, until rsp_ready is high.
  - The other rsp_valid stays 0.
  - On the response handshake in cycle D, clear rsp_valid and go to IDLE; the earliest next req_ready is in cycle D+1.
  - Minimum throughput: one op per EXEC_CYCLES+2 cycles.
- Requester obligations: req_valid and its operands must stay stable until ready. A req_valid that drops before being granted is simply not served.
- Simultaneous events: a new request that arrives while busy waits; the arbiter performs no queueing. Both requests arriving in the same IDLE cycle are resolved by round-robin only.
- Response data: rsp*_r/flags of the non-granted requester keep their last values; rsp_valid alone qualifies them.
- Reset mid-operation: rst in any state aborts the operation; no response is produced and the pending requester must re-present its request.
- Arithmetic: the block does no arithmetic itself. The ALU result passes through unmodified and all widths are WIDTH.

Decomposition:
- Shared package: aluc op-code constants (e.g. ALUC_ADDU=4'b0000), FSM state encoding (IDLE/EXEC/RESP), flag bit-index constants (FLAG_ZERO=0, FLAG_CARRY=1, FLAG_NEG=2, FLAG_OVF=3).
- One natural sub-module: rr_arbiter2, a 2-way round-robin winner selection taking valid[1:0] and last_grant. The FSM, operand/result registers and counter stay in the top.
- The ALU is instantiated outside this block.

Test Plan:
- Single op, EXEC_CYCLES=1: req0 a=32'h00000005, b=32'hffff000f, aluc=0000 (add) accepted in cycle C -> rsp0_valid in C+2, rsp0_r=32'hffff0014, zero=0, negative=1 (with the team ALU model). rsp1_valid stays 0.
- Tie: req0 and req1 both valid from reset (req1 aluc=0010 sub, a=5, b=5) -> req0 is served first. req1_ready rises the cycle after rsp0's handshake, and rsp1 gives r=0, zero=1.
- Fairness: both requesters continuously valid for 6 ops -> grant_id sequence is 0,1,0,1,0,1; the bench checks no requester is starved.
- Backpressure: rsp0_ready held low for 5 cycles -> rsp0_valid, r and flags stay stable for all 5 cycles, both req*_ready stay 0, and busy=1 throughout.
- Latency, EXEC_CYCLES=3: op accepted in cycle C -> alu_a/b/aluc stable for cycles C+1..C+3, and rsp_valid rises exactly in C+4.
- Reset mid-EXEC: rst asserted for 1 cycle during EXEC -> next cycle shows all rsp_valid=0, busy=0, alu_*=0. Re-presented req0 is then accepted with correct results.
